// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use hazard detection and bubble insertion
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [4:0]       rs1_addr_i,
    input  logic [4:0]       rs2_addr_i,
    input  logic [4:0]       rd_addr_i,
    input  logic             uses_rs1_i,
    input  logic             uses_rs2_i,
    input  logic [XLEN-1:0]  rs1_data_i,
    input  logic [XLEN-1:0]  rs2_data_i,
    input  logic [XLEN-1:0]  imm_i,
    input  logic [2:0]       funct3_i,
    input  logic             reg_write_en_i,
    input  logic             rs1_pc_sel_i,
    input  logic             rs2_imm_sel_i,
    input  logic             is_branch_instr_i,
    input  logic             is_load_instr_i,
    input  logic             is_store_instr_i,
    input  logic             unconditional_branch_i,
    input  logic [1:0]       wb_sel_i,
    input  logic [3:0]       alu_op_i,
    input  logic             flush_i,
    input  logic             ex_stall_i,
    output logic             valid_o,
    output logic [XLEN-1:0]  pc_o,
    output logic [4:0]       rs1_addr_o,
    output logic [4:0]       rs2_addr_o,
    output logic [4:0]       rd_addr_o,
    output logic [XLEN-1:0]  rs1_data_o,
    output logic [XLEN-1:0]  rs2_data_o,
    output logic [XLEN-1:0]  imm_o,
    output logic [2:0]       funct3_o,
    output logic             reg_write_en_o,
    output logic             rs1_pc_sel_o,
    output logic             rs2_imm_sel_o,
    output logic             is_branch_instr_o,
    output logic             is_load_instr_o,
    output logic             is_store_instr_o,
    output logic             unconditional_branch_o,
    output logic [1:0]       wb_sel_o,
    output logic [3:0]       alu_op_o,
    output logic             stall_o,
    output logic [CNT_W-1:0] bubble_count_o
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [2:0]      funct3;
        logic            reg_write_en;
        logic            rs1_pc_sel;
        logic            rs2_imm_sel;
        logic            is_branch;
        logic            is_load;
        logic            is_store;
        logic            uncond;
        logic [1:0]      wb_sel;
        logic [3:0]      alu_op;
    } ex_t;

    ex_t              ex_d, ex_q, capture;
    logic [CNT_W-1:0] bubble_count_d, bubble_count_q;
    logic             load_use;

    assign load_use = ex_q.valid && ex_q.is_load && (ex_q.rd_addr != 5'd0) && valid_i &&
                      ((uses_rs1_i && (rs1_addr_i == ex_q.rd_addr)) ||
                       (uses_rs2_i && (rs2_addr_i == ex_q.rd_addr)));

    // Gated by reset so upstream never sees a stall while the pipe is held in reset.
    assign stall_o = rst_ni && !flush_i && (ex_stall_i || load_use);

    always_comb begin
        capture          = '0;
        capture.valid    = valid_i;
        capture.pc       = pc_i;
        capture.rs1_addr = rs1_addr_i;
        capture.rs2_addr = rs2_addr_i;
        capture.rd_addr  = rd_addr_i;
        capture.rs1_data = rs1_data_i;
        capture.rs2_data = rs2_data_i;
        capture.imm      = imm_i;
        capture.funct3   = funct3_i;
        // Control fields stay zero for an empty slot so execute cannot act on stale decode.
        if (valid_i) begin
            capture.reg_write_en = reg_write_en_i;
            capture.rs1_pc_sel   = rs1_pc_sel_i;
            capture.rs2_imm_sel  = rs2_imm_sel_i;
            capture.is_branch    = is_branch_instr_i;
            capture.is_load      = is_load_instr_i;
            capture.is_store     = is_store_instr_i;
            capture.uncond       = unconditional_branch_i;
            capture.wb_sel       = wb_sel_i;
            capture.alu_op       = alu_op_i;
        end
    end

    always_comb begin
        ex_d           = ex_q;
        bubble_count_d = bubble_count_q;
        if (flush_i) begin
            ex_d = '0;
        end else if (ex_stall_i) begin
            ex_d = ex_q;
        end else if (load_use) begin
            ex_d = '0;
            if (bubble_count_q != {CNT_W{1'b1}}) begin
                bubble_count_d = bubble_count_q + CNT_W'(1);
            end
        end else begin
            ex_d = capture;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_q           <= '0;
            bubble_count_q <= '0;
        end else begin
            ex_q           <= ex_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign valid_o                = ex_q.valid;
    assign pc_o                   = ex_q.pc;
    assign rs1_addr_o             = ex_q.rs1_addr;
    assign rs2_addr_o             = ex_q.rs2_addr;
    assign rd_addr_o              = ex_q.rd_addr;
    assign rs1_data_o             = ex_q.rs1_data;
    assign rs2_data_o             = ex_q.rs2_data;
    assign imm_o                  = ex_q.imm;
    assign funct3_o               = ex_q.funct3;
    assign reg_write_en_o         = ex_q.reg_write_en;
    assign rs1_pc_sel_o           = ex_q.rs1_pc_sel;
    assign rs2_imm_sel_o          = ex_q.rs2_imm_sel;
    assign is_branch_instr_o      = ex_q.is_branch;
    assign is_load_instr_o        = ex_q.is_load;
    assign is_store_instr_o       = ex_q.is_store;
    assign unconditional_branch_o = ex_q.uncond;
    assign wb_sel_o               = ex_q.wb_sel;
    assign alu_op_o               = ex_q.alu_op;
    assign bubble_count_o         = bubble_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage with a 2-bit bubble counter
module tb_id_ex_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 2;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
        logic        rwe;
        logic        load;
        logic        uncond;
        logic [3:0]  alu;
    } ins_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] rs1_data;
        logic [31:0] imm;
        logic        rwe;
        logic        load;
        logic        uncond;
        logic [1:0]  wb_sel;
        logic [3:0]  alu;
        logic        stall;
        logic [1:0]  cnt;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_ni;
    logic valid_i, uses_rs1_i, uses_rs2_i, reg_write_en_i, rs1_pc_sel_i, rs2_imm_sel_i;
    logic is_branch_instr_i, is_load_instr_i, is_store_instr_i, unconditional_branch_i;
    logic flush_i, ex_stall_i;
    logic [XLEN-1:0] pc_i, rs1_data_i, rs2_data_i, imm_i;
    logic [4:0] rs1_addr_i, rs2_addr_i, rd_addr_i;
    logic [2:0] funct3_i;
    logic [1:0] wb_sel_i;
    logic [3:0] alu_op_i;

    logic valid_o, reg_write_en_o, rs1_pc_sel_o, rs2_imm_sel_o, is_branch_instr_o;
    logic is_load_instr_o, is_store_instr_o, unconditional_branch_o, stall_o;
    logic [XLEN-1:0] pc_o, rs1_data_o, rs2_data_o, imm_o;
    logic [4:0] rs1_addr_o, rs2_addr_o, rd_addr_o;
    logic [2:0] funct3_o;
    logic [1:0] wb_sel_o;
    logic [3:0] alu_op_o;
    logic [CNT_W-1:0] bubble_count_o;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always #5 clk_i = ~clk_i;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .pc_i(pc_i),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i),
        .uses_rs1_i(uses_rs1_i), .uses_rs2_i(uses_rs2_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i), .funct3_i(funct3_i),
        .reg_write_en_i(reg_write_en_i), .rs1_pc_sel_i(rs1_pc_sel_i), .rs2_imm_sel_i(rs2_imm_sel_i),
        .is_branch_instr_i(is_branch_instr_i), .is_load_instr_i(is_load_instr_i),
        .is_store_instr_i(is_store_instr_i), .unconditional_branch_i(unconditional_branch_i),
        .wb_sel_i(wb_sel_i), .alu_op_i(alu_op_i), .flush_i(flush_i), .ex_stall_i(ex_stall_i),
        .valid_o(valid_o), .pc_o(pc_o), .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
        .rd_addr_o(rd_addr_o), .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o), .imm_o(imm_o),
        .funct3_o(funct3_o), .reg_write_en_o(reg_write_en_o), .rs1_pc_sel_o(rs1_pc_sel_o),
        .rs2_imm_sel_o(rs2_imm_sel_o), .is_branch_instr_o(is_branch_instr_o),
        .is_load_instr_o(is_load_instr_o), .is_store_instr_o(is_store_instr_o),
        .unconditional_branch_o(unconditional_branch_o), .wb_sel_o(wb_sel_o), .alu_op_o(alu_op_o),
        .stall_o(stall_o), .bubble_count_o(bubble_count_o)
    );

    function automatic ins_t mk(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                                input logic u2, input logic rwe, input logic load,
                                input logic uncond, input logic [3:0] alu);
        ins_t r;
        r.valid = v; r.pc = pc; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2;
        r.rwe = rwe; r.load = load; r.uncond = uncond; r.alu = alu;
        return r;
    endfunction

    // Expected execute outputs once instruction i has been captured.
    function automatic exp_t e_instr(input ins_t i, input logic stall, input logic [1:0] cnt);
        exp_t e;
        e          = '0;
        e.valid    = i.valid;
        e.pc       = i.pc;
        e.rd       = i.rd;
        e.rs1_data = i.pc ^ 32'hA5A5_0000;
        e.imm      = i.pc + 32'd100;
        if (i.valid) begin
            e.rwe    = i.rwe;
            e.load   = i.load;
            e.uncond = i.uncond;
            e.wb_sel = i.load ? 2'b01 : 2'b00;
            e.alu    = i.alu;
        end
        e.stall = stall;
        e.cnt   = cnt;
        return e;
    endfunction

    function automatic exp_t e_bubble(input logic stall, input logic [1:0] cnt);
        exp_t e;
        e       = '0;
        e.stall = stall;
        e.cnt   = cnt;
        return e;
    endfunction

    task automatic step(input ins_t i, input logic fl, input logic es, input logic rst,
                        input exp_t e);
        @(posedge clk_i);
        #1;
        rst_ni                 = rst;
        valid_i                = i.valid;
        pc_i                   = i.pc;
        rd_addr_i              = i.rd;
        rs1_addr_i             = i.rs1;
        rs2_addr_i             = i.rs2;
        uses_rs1_i             = i.u1;
        uses_rs2_i             = i.u2;
        rs1_data_i             = i.pc ^ 32'hA5A5_0000;
        rs2_data_i             = i.pc + 32'd7;
        imm_i                  = i.pc + 32'd100;
        funct3_i               = i.pc[4:2];
        reg_write_en_i         = i.rwe;
        is_load_instr_i        = i.load;
        is_store_instr_i       = 1'b0;
        is_branch_instr_i      = i.uncond;
        unconditional_branch_i = i.uncond;
        rs1_pc_sel_i           = i.uncond;
        rs2_imm_sel_i          = !i.u2;
        wb_sel_i               = i.load ? 2'b01 : 2'b00;
        alu_op_i               = i.alu;
        flush_i                = fl;
        ex_stall_i             = es;
        exp_q.push_back(e);
    endtask

    always @(negedge clk_i) begin
        exp_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a.valid = valid_o; a.pc = pc_o; a.rd = rd_addr_o; a.rs1_data = rs1_data_o;
            a.imm = imm_o; a.rwe = reg_write_en_o; a.load = is_load_instr_o;
            a.uncond = unconditional_branch_o; a.wb_sel = wb_sel_o; a.alu = alu_op_o;
            a.stall = stall_o; a.cnt = bubble_count_o;
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cyc%0d: got v=%b pc=%h rd=%0d d1=%h imm=%h rwe=%b ld=%b uc=%b wb=%b alu=%h st=%b cnt=%0d, want v=%b pc=%h rd=%0d d1=%h imm=%h rwe=%b ld=%b uc=%b wb=%b alu=%h st=%b cnt=%0d",
                         cyc, a.valid, a.pc, a.rd, a.rs1_data, a.imm, a.rwe, a.load, a.uncond,
                         a.wb_sel, a.alu, a.stall, a.cnt, e.valid, e.pc, e.rd, e.rs1_data,
                         e.imm, e.rwe, e.load, e.uncond, e.wb_sel, e.alu, e.stall, e.cnt);
            end
            cyc++;
        end
    end

    initial begin
        ins_t nop, addi, add2, lw5, add6, lw0, addx0, lw5b, jal, alu, oth;
        ins_t lw5c, dep, nxt, lw5d, dep2, prev, l, d, inv, dep3, lw5e, dep4;
        logic [1:0] cnt;

        nop   = mk(0, 32'h00, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0);
        addi  = mk(1, 32'h00, 1, 0, 0, 1, 0, 1, 0, 0, 4'h0);
        add2  = mk(1, 32'h04, 2, 1, 1, 1, 1, 1, 0, 0, 4'h0);
        lw5   = mk(1, 32'h08, 5, 2, 0, 1, 0, 1, 1, 0, 4'h0);
        add6  = mk(1, 32'h0C, 6, 5, 7, 1, 1, 1, 0, 0, 4'h0);
        lw0   = mk(1, 32'h10, 0, 3, 0, 1, 0, 1, 1, 0, 4'h0);
        addx0 = mk(1, 32'h14, 8, 0, 0, 1, 0, 1, 0, 0, 4'h0);
        lw5b  = mk(1, 32'h18, 5, 2, 0, 1, 0, 1, 1, 0, 4'h0);
        jal   = mk(1, 32'h1C, 1, 5, 5, 0, 0, 1, 0, 1, 4'h0);
        alu   = mk(1, 32'h20, 9, 1, 0, 1, 0, 1, 0, 0, 4'h3);
        oth   = mk(1, 32'h24, 10, 9, 0, 1, 0, 1, 0, 0, 4'h6);
        lw5c  = mk(1, 32'h28, 5, 2, 0, 1, 0, 1, 1, 0, 4'h0);
        dep   = mk(1, 32'h2C, 11, 0, 5, 0, 1, 1, 0, 0, 4'h0);
        nxt   = mk(1, 32'h40, 12, 3, 4, 1, 1, 1, 0, 0, 4'h2);
        lw5d  = mk(1, 32'h44, 5, 2, 0, 1, 0, 1, 1, 0, 4'h0);
        dep2  = mk(1, 32'h48, 13, 5, 0, 1, 0, 1, 0, 0, 4'h1);

        rst_ni = 1'b1;
        step_idle();
        #2 rst_ni = 1'b0;

        step(nop,   0, 1, 0, e_bubble(0, 0));
        step(addi,  0, 0, 1, e_bubble(0, 0));
        step(add2,  0, 0, 1, e_instr(addi, 0, 0));
        step(lw5,   0, 0, 1, e_instr(add2, 0, 0));
        step(add6,  0, 0, 1, e_instr(lw5, 1, 0));
        step(add6,  0, 0, 1, e_bubble(0, 1));
        step(lw0,   0, 0, 1, e_instr(add6, 0, 1));
        step(addx0, 0, 0, 1, e_instr(lw0, 0, 1));
        step(lw5b,  0, 0, 1, e_instr(addx0, 0, 1));
        step(jal,   0, 0, 1, e_instr(lw5b, 0, 1));
        step(alu,   0, 0, 1, e_instr(jal, 0, 1));
        step(oth,   0, 1, 1, e_instr(alu, 1, 1));
        step(oth,   0, 1, 1, e_instr(alu, 1, 1));
        step(oth,   0, 1, 1, e_instr(alu, 1, 1));
        step(oth,   0, 0, 1, e_instr(alu, 0, 1));
        step(lw5c,  0, 0, 1, e_instr(oth, 0, 1));
        step(dep,   1, 0, 1, e_instr(lw5c, 0, 1));
        step(nxt,   0, 0, 1, e_bubble(0, 1));
        step(lw5d,  0, 0, 1, e_instr(nxt, 0, 1));
        step(dep2,  0, 1, 1, e_instr(lw5d, 1, 1));
        step(dep2,  0, 0, 1, e_instr(lw5d, 1, 1));
        step(dep2,  0, 0, 1, e_bubble(0, 2));

        cnt  = 2'd2;
        prev = dep2;
        for (int k = 0; k < 3; k++) begin
            l = mk(1, 32'h100 + 32'(16 * k), 5, 2, 0, 1, 0, 1, 1, 0, 4'h0);
            d = mk(1, 32'h104 + 32'(16 * k), 13, 5, 0, 1, 0, 1, 0, 0, 4'h4);
            step(l, 0, 0, 1, e_instr(prev, 0, cnt));
            step(d, 0, 0, 1, e_instr(l, 1, cnt));
            cnt = 2'd3;
            step(d, 0, 0, 1, e_bubble(0, cnt));
            prev = d;
        end

        inv  = mk(0, 32'h200, 5, 0, 0, 0, 0, 1, 1, 1, 4'h5);
        dep3 = mk(1, 32'h204, 14, 5, 0, 1, 0, 1, 0, 0, 4'h0);
        lw5e = mk(1, 32'h208, 5, 2, 0, 1, 0, 1, 1, 0, 4'h0);
        dep4 = mk(1, 32'h20C, 15, 0, 5, 0, 1, 1, 0, 0, 4'h0);
        step(inv,  0, 0, 1, e_instr(prev, 0, 3));
        step(dep3, 0, 0, 1, e_instr(inv, 0, 3));
        step(lw5e, 0, 0, 1, e_instr(dep3, 0, 3));
        step(dep4, 0, 1, 1, e_instr(lw5e, 1, 3));
        step(dep4, 0, 1, 0, e_bubble(0, 0));
        step(nop,  0, 0, 0, e_bubble(0, 0));

        repeat (3) @(posedge clk_i);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    task automatic step_idle();
        valid_i = 0; pc_i = '0; rd_addr_i = '0; rs1_addr_i = '0; rs2_addr_i = '0;
        uses_rs1_i = 0; uses_rs2_i = 0; rs1_data_i = '0; rs2_data_i = '0; imm_i = '0;
        funct3_i = '0; reg_write_en_i = 0; is_load_instr_i = 0; is_store_instr_i = 0;
        is_branch_instr_i = 0; unconditional_branch_i = 0; rs1_pc_sel_i = 0;
        rs2_imm_sel_i = 0; wb_sel_i = '0; alu_op_i = '0; flush_i = 0; ex_stall_i = 0;
    endtask

endmodule
